interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Priority interrupt controller that drives the processor's interrupt request side (`INT`, `NMI`) and consumes its acknowledge (`INA`). It latches rising edges on up to `N_IRQ` external lines and applies a software mask. It presents one request at a time with a stable vector and holds further maskable requests until software issues end-of-interrupt. It sits between peripherals and the multicycle core, on the same clock.

## Interface
- `N_IRQ`, 8, number of maskable interrupt lines (2..16)
- `VEC_W`, 3, vector width, equal to clog2(`N_IRQ`)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `irq`  in  `N_IRQ`  maskable interrupt sources, rising-edge sensitive, already synchronous to `clk`
- `nmi_in`  in  1  non-maskable source, rising-edge sensitive
- `INA`  in  1  processor interrupt acknowledge, level, one or more cycles
- `mask_we`  in  1  mask register write strobe
- `mask_wdata`  in  `N_IRQ`  new mask; 1 = line masked
- `eoi`  in  1  end-of-interrupt pulse from software
- `INT`  out  1  maskable interrupt request to processor
- `NMI`  out  1  non-maskable request to processor
- `vector`  out  `VEC_W`  index of the line being requested or serviced
- `pending`  out  `N_IRQ`  latched, not-yet-acknowledged edges
- `in_service`  out  1  a maskable interrupt is acknowledged and awaiting `eoi`

## Operation
- Edge detect: `irq_prev` is registered each cycle. `pending[i]` is set when `irq[i] & ~irq_prev[i]`. It is cleared only when line i is acknowledged. If set and clear coincide on the same bit, set wins.
- `nmi_pend` is set on a rising edge of `nmi_in` and cleared on NMI acknowledge. The same set-wins rule applies.
- Mask: `mask_we` loads `mask` on the next edge. Masking does not clear `pending`. Unmasking a pending line makes it eligible next cycle.
- Eligible set = `pending & ~mask`. The lowest index has the highest priority.
- States:
  - IDLE: if `nmi_pend`, go to NMI_REQ (ret=IDLE). Else if the eligible set is non-empty, latch the winning index into `vector` and go to REQ.
  - REQ: `INT`=1 and `vector` is frozen.
    - If `nmi_pend`, go to NMI_REQ (ret=IDLE). `INT` drops and the line stays pending.
    - Else if `INA`=1, clear `pending[vector]` and go to SERVICE.
  - SERVICE: `in_service`=1 and `vector` holds the serviced line.
    - If `nmi_pend`, go to NMI_REQ (ret=SERVICE).
    - Else if `eoi`, go to IDLE.
    - `INT` is not raised in this state; there is no nesting of maskable interrupts.
  - NMI_REQ: `NMI`=1. On `INA`=1, clear `nmi_pend` and go to NMI_ACK.
  - NMI_ACK: wait for `INA`=0, then go to ret.
- `vector` is frozen in NMI_REQ and NMI_ACK. It is not driven to an NMI value, because the processor distinguishes NMI by its own line.
- `INA`=1 while in REQ is also held until deasserted: SERVICE ignores `INA`.
- `eoi` outside SERVICE is ignored.
- `INT` and `NMI` are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `INT`=0, `NMI`=0, `vector`=0, `pending`=0, `in_service`=0, state=IDLE, `mask`=all ones, `irq_prev`=0, `nmi_pend`=0.
- Request latency: an `irq` edge sampled at edge k sets `pending` at k+1. `INT` is high after edge k+2, provided the line is unmasked and the controller is idle.
- Acknowledge: `INA` sampled high at edge a clears the pending bit and drops `INT` after edge a. `in_service` rises at the same edge.
- `eoi` sampled at edge e drops `in_service` after e. A further eligible line raises `INT` after e+1.
- An NMI edge at k raises `NMI` after k+2 from any non-NMI state. It preempts REQ in the same cycle that `nmi_pend` is seen.
- Reset mid-operation: all state is lost immediately (asynchronous), including pending edges, in-service status and mask. A line still held high after reset does not retrigger until it falls and rises again.

## Test plan
- Reset, write `mask`=0x00, pulse `irq[5]` -> `pending`=0x20; `INT`=1 with `vector`=5 two cycles after the edge. Hold `INA` -> `INT`=0, `pending`=0x00, `in_service`=1. Pulse `eoi` -> `in_service`=0.
- Edges on `irq[6]` and `irq[2]` in the same cycle -> `vector`=2 first. After `INA` then `eoi` -> `vector`=6 request.
- With `mask`=0xFF, pulse `irq[3]` -> `pending`=0x08 and `INT` stays 0. Write `mask`=0xF7 -> `INT`=1, `vector`=3.
- `INT` active for line 4, then an `nmi_in` edge -> `INT`=0 and `NMI`=1, with `pending[4]` still 1. `INA` pulse -> `NMI`=0. After `INA` falls -> `INT`=1, `vector`=4.
- In SERVICE for line 1, with `irq[0]` edge plus an NMI edge -> `NMI` is served and control returns to SERVICE with `in_service`=1. `INT` stays 0 until `eoi`, then `vector`=0.
- Assert `reset` while `INT`=1 and `pending`=0x81 -> all outputs are at their reset values on the same cycle and `mask`=0xFF.

Source files
------------

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: latches rising edges on maskable lines and an NMI,
// presents one request at a time to the core and holds maskable requests until eoi.
module interrupt_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             nmi_in,
  input  logic             INA,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             eoi,
  output logic             INT,
  output logic             NMI,
  output logic [VEC_W-1:0] vector,
  output logic [N_IRQ-1:0] pending,
  output logic             in_service
);

  // state     | meaning
  // S_IDLE    | nothing requested; pick NMI or lowest eligible line
  // S_REQ     | INT raised for vector, waiting for INA
  // S_SERVICE | maskable interrupt acknowledged, waiting for eoi
  // S_NMI_REQ | NMI raised, waiting for INA
  // S_NMI_ACK | NMI acknowledged, waiting for INA to fall, then return
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE,
    S_NMI_REQ,
    S_NMI_ACK
  } state_t;

  state_t state, state_nx;
  logic ret_svc, ret_svc_nx;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] mask;
  logic nmi_prev;
  logic nmi_pend;
  logic armed;

  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] set_bits;
  logic [N_IRQ-1:0] clr_bits;
  logic [VEC_W-1:0] win;
  logic has_elig;
  logic load_vec;
  logic clr_vec;
  logic clr_nmi;
  logic nmi_set;

  assign elig     = pending & ~mask;
  assign has_elig = |elig;
  // The first cycle after reset only primes the edge history, so lines held
  // high across reset do not register as fresh edges.
  assign set_bits = armed ? (irq & ~irq_prev) : '0;
  assign nmi_set  = armed & nmi_in & ~nmi_prev;

  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win = VEC_W'(i);
    end
  end

  always_comb begin
    clr_bits = '0;
    if (clr_vec) clr_bits[vector] = 1'b1;
  end

  always_comb begin
    state_nx   = state;
    ret_svc_nx = ret_svc;
    load_vec   = 1'b0;
    clr_vec    = 1'b0;
    clr_nmi    = 1'b0;
    case (state)
      S_IDLE: begin
        if (nmi_pend) begin
          state_nx   = S_NMI_REQ;
          ret_svc_nx = 1'b0;
        end else if (has_elig) begin
          load_vec = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (nmi_pend) begin
          state_nx   = S_NMI_REQ;
          ret_svc_nx = 1'b0;
        end else if (INA) begin
          clr_vec  = 1'b1;
          state_nx = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (nmi_pend) begin
          state_nx   = S_NMI_REQ;
          ret_svc_nx = 1'b1;
        end else if (eoi) begin
          state_nx = S_IDLE;
        end
      end
      S_NMI_REQ: begin
        if (INA) begin
          clr_nmi  = 1'b1;
          state_nx = S_NMI_ACK;
        end
      end
      S_NMI_ACK: begin
        if (!INA) state_nx = ret_svc ? S_SERVICE : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ret_svc    <= 1'b0;
      irq_prev   <= '0;
      nmi_prev   <= 1'b0;
      nmi_pend   <= 1'b0;
      armed      <= 1'b0;
      mask       <= '1;
      pending    <= '0;
      vector     <= '0;
      INT        <= 1'b0;
      NMI        <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state    <= state_nx;
      ret_svc  <= ret_svc_nx;
      irq_prev <= irq;
      nmi_prev <= nmi_in;
      armed    <= 1'b1;
      // set wins over a coincident clear
      pending  <= (pending & ~clr_bits) | set_bits;
      nmi_pend <= (nmi_pend & ~clr_nmi) | nmi_set;
      if (mask_we) mask <= mask_wdata;
      if (load_vec) vector <= win;
      INT <= (state_nx == S_REQ);
      NMI <= (state_nx == S_NMI_REQ);
      // an NMI taken from SERVICE does not end the maskable interrupt
      in_service <= (state_nx == S_SERVICE) ||
                    (ret_svc_nx && (state_nx == S_NMI_REQ || state_nx == S_NMI_ACK));
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: each task drives one scenario and checks inline.
module tb_interrupt_controller;

  localparam int N_IRQ = 8;
  localparam int VEC_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IRQ-1:0] irq;
  logic             nmi_in;
  logic             INA;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             eoi;
  logic             INT;
  logic             NMI;
  logic [VEC_W-1:0] vector;
  logic [N_IRQ-1:0] pending;
  logic             in_service;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
    .clk(clk), .reset(reset), .irq(irq), .nmi_in(nmi_in), .INA(INA),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .eoi(eoi),
    .INT(INT), .NMI(NMI), .vector(vector), .pending(pending), .in_service(in_service)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (INT && NMI) begin errors++; $display("FAIL int_nmi_exclusive INT=%0b NMI=%0b", INT, NMI); end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_and_eoi();
    INA = 1'b1; tick(); INA = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq = '0; nmi_in = 1'b0; INA = 1'b0;
    mask_we = 1'b0; mask_wdata = '0; eoi = 1'b0;
    tick(2);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rst_int got=%0b exp=0", INT); end
    checks++; if (NMI !== 1'b0) begin errors++; $display("FAIL rst_nmi got=%0b exp=0", NMI); end
    checks++; if (vector !== 3'd0) begin errors++; $display("FAIL rst_vector got=%0d exp=0", vector); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending got=%h exp=00", pending); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_in_service got=%0b exp=0", in_service); end
    reset = 1'b0;
    tick(2);
    checks++; if (INT !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL rst_idle INT=%0b pending=%h exp 0/00", INT, pending); end
  endtask

  // Mask resets to all ones; unmasking a pending line raises INT one cycle later.
  task automatic test_mask();
    irq = 8'h08; tick(); irq = '0; tick(2);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL mask_pending got=%h exp=08", pending); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_int_held got=%0b exp=0", INT); end
    mask_we = 1'b1; mask_wdata = 8'hF7; tick(); mask_we = 1'b0;
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_int_load_edge got=%0b exp=0", INT); end
    tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd3) begin errors++; $display("FAIL mask_unmask INT=%0b vector=%0d exp 1/3", INT, vector); end
    ack_and_eoi();
    checks++; if (pending !== 8'h00 || in_service !== 1'b0) begin errors++; $display("FAIL mask_done pending=%h in_service=%0b exp 00/0", pending, in_service); end
  endtask

  task automatic test_basic();
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    irq = 8'h20; tick();
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL basic_pending got=%h exp=20", pending); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL basic_int_early got=%0b exp=0", INT); end
    irq = '0; tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd5) begin errors++; $display("FAIL basic_req INT=%0b vector=%0d exp 1/5", INT, vector); end
    INA = 1'b1; tick();
    checks++; if (INT !== 1'b0 || pending !== 8'h00 || in_service !== 1'b1) begin
      errors++; $display("FAIL basic_ack INT=%0b pending=%h in_service=%0b exp 0/00/1", INT, pending, in_service); end
    tick();
    checks++; if (in_service !== 1'b1 || INT !== 1'b0) begin errors++; $display("FAIL basic_ina_held in_service=%0b INT=%0b exp 1/0", in_service, INT); end
    INA = 1'b0; tick();
    checks++; if (in_service !== 1'b1 || vector !== 3'd5) begin errors++; $display("FAIL basic_service in_service=%0b vector=%0d exp 1/5", in_service, vector); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL basic_eoi got=%0b exp=0", in_service); end
  endtask

  task automatic test_priority();
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (INT !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL prio_stray_eoi INT=%0b in_service=%0b exp 0/0", INT, in_service); end
    irq = 8'h44; tick(); irq = '0; tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd2 || pending !== 8'h44) begin
      errors++; $display("FAIL prio_first INT=%0b vector=%0d pending=%h exp 1/2/44", INT, vector, pending); end
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (pending !== 8'h40 || in_service !== 1'b1) begin errors++; $display("FAIL prio_ack pending=%h in_service=%0b exp 40/1", pending, in_service); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (INT !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL prio_eoi INT=%0b in_service=%0b exp 0/0", INT, in_service); end
    tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd6) begin errors++; $display("FAIL prio_second INT=%0b vector=%0d exp 1/6", INT, vector); end
    ack_and_eoi();
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL prio_done pending=%h exp=00", pending); end
  endtask

  task automatic test_nmi_preempt();
    irq = 8'h10; tick(); irq = '0; tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd4) begin errors++; $display("FAIL nmip_req INT=%0b vector=%0d exp 1/4", INT, vector); end
    nmi_in = 1'b1; tick(); nmi_in = 1'b0;
    checks++; if (INT !== 1'b1 || NMI !== 1'b0) begin errors++; $display("FAIL nmip_latch INT=%0b NMI=%0b exp 1/0", INT, NMI); end
    tick();
    checks++; if (INT !== 1'b0 || NMI !== 1'b1 || pending !== 8'h10 || vector !== 3'd4) begin
      errors++; $display("FAIL nmip_preempt INT=%0b NMI=%0b pending=%h vector=%0d exp 0/1/10/4", INT, NMI, pending, vector); end
    INA = 1'b1; tick();
    checks++; if (NMI !== 1'b0 || INT !== 1'b0) begin errors++; $display("FAIL nmip_ack NMI=%0b INT=%0b exp 0/0", NMI, INT); end
    tick();
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL nmip_ina_held INT=%0b exp 0", INT); end
    INA = 1'b0; tick(2);
    checks++; if (INT !== 1'b1 || vector !== 3'd4) begin errors++; $display("FAIL nmip_resume INT=%0b vector=%0d exp 1/4", INT, vector); end
    ack_and_eoi();
  endtask

  task automatic test_nmi_in_service();
    irq = 8'h02; tick(); irq = '0; tick();
    INA = 1'b1; tick(); INA = 1'b0;
    checks++; if (in_service !== 1'b1 || vector !== 3'd1) begin errors++; $display("FAIL nmis_service in_service=%0b vector=%0d exp 1/1", in_service, vector); end
    irq = 8'h01; nmi_in = 1'b1; tick(); irq = '0; nmi_in = 1'b0; tick();
    checks++; if (NMI !== 1'b1 || INT !== 1'b0 || pending !== 8'h01) begin
      errors++; $display("FAIL nmis_nmi NMI=%0b INT=%0b pending=%h exp 1/0/01", NMI, INT, pending); end
    INA = 1'b1; tick(); INA = 1'b0; tick();
    checks++; if (in_service !== 1'b1 || NMI !== 1'b0 || INT !== 1'b0 || vector !== 3'd1) begin
      errors++; $display("FAIL nmis_return in_service=%0b NMI=%0b INT=%0b vector=%0d exp 1/0/0/1", in_service, NMI, INT, vector); end
    tick(3);
    checks++; if (INT !== 1'b0 || in_service !== 1'b1) begin errors++; $display("FAIL nmis_no_nest INT=%0b in_service=%0b exp 0/1", INT, in_service); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL nmis_eoi in_service=%0b exp 0", in_service); end
    tick();
    checks++; if (INT !== 1'b1 || vector !== 3'd0) begin errors++; $display("FAIL nmis_next INT=%0b vector=%0d exp 1/0", INT, vector); end
    ack_and_eoi();
  endtask

  task automatic test_reset_mid();
    irq = 8'h81; tick(2);
    checks++; if (INT !== 1'b1 || pending !== 8'h81 || vector !== 3'd0) begin
      errors++; $display("FAIL rmid_setup INT=%0b pending=%h vector=%0d exp 1/81/0", INT, pending, vector); end
    #3 reset = 1'b1;
    #1;
    checks++; if (INT !== 1'b0 || NMI !== 1'b0 || vector !== 3'd0 || pending !== 8'h00 || in_service !== 1'b0) begin
      errors++; $display("FAIL rmid_async INT=%0b NMI=%0b vector=%0d pending=%h in_service=%0b exp 0/0/0/00/0", INT, NMI, vector, pending, in_service); end
    tick(); reset = 1'b0;
    tick(2);
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL rmid_no_retrigger pending=%h exp=00", pending); end
    irq = '0; tick(); irq = 8'h01; tick();
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL rmid_new_edge pending=%h exp=01", pending); end
    tick(2);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rmid_mask_reset INT=%0b exp 0", INT); end
    irq = '0;
  endtask

  initial begin
    test_reset();
    test_mask();
    test_basic();
    test_priority();
    test_nmi_preempt();
    test_nmi_in_service();
    test_reset_mid();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
